// File: rtl/hit_judge.sv
// -----------------------------------------------------------------------------
// hit_judge -- rhythm-game note judgment.
//
// The raw player button is synchronized and debounced into a single press
// event. A note pulse opens a judgment window. A press inside the window is a
// hit, graded perfect during its first PERFECT_CYC cycles. A window that
// expires without a press is a miss. All outputs are registered and pulse
// exactly one cycle after the deciding event.
//
// Optional feature: define EMPTY_PRESS_MISS_EN to punish a press made while no
// window is open (and with no note that cycle) with an o_Miss pulse. With the
// macro undefined, such a press is ignored.
//
// Parameters:
//   DEBOUNCE_CYC  cycles the synchronized button must disagree with the
//                 debounced level before that level flips
//   WINDOW_CYC    judgment window length in cycles, counted from the note
//   PERFECT_CYC   leading part of the window graded perfect
//                 (1 <= PERFECT_CYC <= WINDOW_CYC)
//
// Ports:
//   i_Clk         clock
//   i_Rst         asynchronous, active-high reset
//   i_Btn         raw button, asynchronous to i_Clk, active-high
//   i_Note        1-cycle pulse, a note reaches the judgment line
//   o_Hit         1-cycle pulse, note judged hit
//   o_Miss        1-cycle pulse, note missed (or empty press, if enabled)
//   o_Perfect     1-cycle pulse, only together with o_Hit
//   o_WindowOpen  level, high while a judgment window is open
// -----------------------------------------------------------------------------
module hit_judge #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned WINDOW_CYC   = 1250000,
  parameter int unsigned PERFECT_CYC  = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Btn,
  input  logic i_Note,
  output logic o_Hit,
  output logic o_Miss,
  output logic o_Perfect,
  output logic o_WindowOpen
);

  // Counter widths; a 1-bit floor keeps degenerate parameter values legal.
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned CW = (WINDOW_CYC   > 1) ? $clog2(WINDOW_CYC)   : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Button synchronizer
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_Btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer and press-event generation
  //
  // db_cnt_q counts consecutive cycles in which the synchronized level
  // disagrees with the debounced level; any agreeing cycle clears it. On the
  // DEBOUNCE_CYC-th disagreeing cycle the level flips. A press event is the
  // registered rising flip, so it is a one-cycle pulse regardless of how long
  // the button stays down, and a release never produces one.
  // ---------------------------------------------------------------------------
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Judgment FSM
  //
  // A press always wins over a same-cycle timeout or new note for the note
  // currently being judged, so o_Hit and o_Miss are mutually exclusive by
  // construction. A note arriving while a window is open first settles the old
  // note (hit or miss) and then restarts the window at 0.
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          perfect_q, perfect_d;
  logic          open_q, open_d;
  logic          in_perfect;

  // Widen the counter so PERFECT_CYC == WINDOW_CYC does not overflow CW.
  assign in_perfect = (32'(win_cnt_q) < PERFECT_CYC);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    perfect_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        win_cnt_d = '0;
        if (i_Note && press_q) begin
          // Press lands exactly on the note: best possible timing.
          hit_d     = 1'b1;
          perfect_d = 1'b1;
        end else if (i_Note) begin
          state_d = ST_OPEN;
        end else if (press_q) begin
`ifdef EMPTY_PRESS_MISS_EN
          miss_d = 1'b1;
`else
          miss_d = 1'b0;
`endif
        end
      end

      ST_OPEN: begin
        if (press_q) begin
          hit_d     = 1'b1;
          perfect_d = in_perfect;
          win_cnt_d = '0;
          state_d   = i_Note ? ST_OPEN : ST_IDLE;
        end else if (i_Note) begin
          miss_d    = 1'b1;
          win_cnt_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          miss_d    = 1'b1;
          win_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
      end
    endcase

    // Registered decode of the state being entered, so o_WindowOpen tracks
    // state_q cycle for cycle without combinational output logic.
    open_d = (state_d == ST_OPEN);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      perfect_q <= 1'b0;
      open_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      perfect_q <= perfect_d;
      open_q    <= open_d;
    end
  end

  assign o_Hit        = hit_q;
  assign o_Miss       = miss_q;
  assign o_Perfect    = perfect_q;
  assign o_WindowOpen = open_q;

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  logic i_Clk = 1'b0;
  logic i_Rst;
  logic i_Btn;
  logic i_Note;
  logic o_Hit;
  logic o_Miss;
  logic o_Perfect;
  logic o_WindowOpen;

  int checks   = 0;
  int failures = 0;
  int hits;
  int misses;

  hit_judge #(
    .DEBOUNCE_CYC(4),
    .WINDOW_CYC  (10),
    .PERFECT_CYC (3)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Btn       (i_Btn),
    .i_Note      (i_Note),
    .o_Hit       (o_Hit),
    .o_Miss      (o_Miss),
    .o_Perfect   (o_Perfect),
    .o_WindowOpen(o_WindowOpen)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance one edge; inputs driven after this are sampled at the next edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic release_btn();
    i_Btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic count_outputs(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hits   += int'(o_Hit);
      misses += int'(o_Miss);
    end
  endtask

  initial begin
    i_Rst  = 1'b1;
    i_Btn  = 1'b0;
    i_Note = 1'b0;
    repeat (3) tick();
    chk("rst_hit",     o_Hit,        0);
    chk("rst_miss",    o_Miss,       0);
    chk("rst_perfect", o_Perfect,    0);
    chk("rst_open",    o_WindowOpen, 0);
    i_Rst = 1'b0;
    tick();

    // Perfect hit: press event lands at counter 2.
    i_Btn = 1'b1;
    repeat (3) tick();
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    chk("perf_open", o_WindowOpen, 1);
    tick(); tick();                            // E1, E2: press pending
    chk("perf_early", o_Hit, 0);
    tick();                                    // E3
    chk("perf_hit",  o_Hit,        1);
    chk("perf_perf", o_Perfect,    1);
    chk("perf_miss", o_Miss,       0);
    chk("perf_open_fall", o_WindowOpen, 0);
    tick();
    chk("perf_pulse_1cyc", o_Hit, 0);
    release_btn();

    // Late (non-perfect) hit: press event at counter 7.
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    tick();                                    // E1
    i_Btn = 1'b1;
    repeat (6) tick();                         // E2..E7
    chk("late_early", o_Hit, 0);
    tick();                                    // E8
    chk("late_hit",  o_Hit,        1);
    chk("late_perf", o_Perfect,    0);
    chk("late_open", o_WindowOpen, 0);
    release_btn();

    // Timeout miss exactly 10 cycles after the window opens.
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    repeat (9) tick();                         // E9
    chk("to_miss_early", o_Miss,       0);
    chk("to_open_early", o_WindowOpen, 1);
    tick();                                    // E10
    chk("to_miss", o_Miss,       1);
    chk("to_hit",  o_Hit,        0);
    chk("to_open", o_WindowOpen, 0);
    tick();
    chk("to_miss_1cyc", o_Miss, 0);

    // Press on the timeout cycle is a hit, not a miss.
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    repeat (3) tick();                         // E3
    i_Btn = 1'b1;
    repeat (6) tick();                         // E4..E9
    tick();                                    // E10
    chk("edge_hit",  o_Hit,     1);
    chk("edge_miss", o_Miss,    0);
    chk("edge_perf", o_Perfect, 0);
    release_btn();

    // 3-cycle glitch inside a window: no press, window times out.
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    i_Btn = 1'b1;
    repeat (3) tick();                         // E1..E3
    i_Btn = 1'b0;
    hits = 0; misses = 0;
    count_outputs(6);                          // E4..E9
    tick();                                    // E10
    chk("glitch_hits", hits + int'(o_Hit), 0);
    chk("glitch_miss", o_Miss, 1);
    repeat (4) tick();

    // Held button: exactly one press event, none while held afterwards.
    i_Note = 1'b1; tick(); i_Note = 1'b0;
    i_Btn = 1'b1;
    hits = 0; misses = 0;
    count_outputs(12);
    chk("hold_hits",   hits,   1);
    chk("hold_misses", misses, 0);
    i_Note = 1'b1; tick(); i_Note = 1'b0;
    hits = 0; misses = 0;
    count_outputs(9);
    chk("hold_no_repress", hits, 0);
    tick();
    chk("hold_timeout_miss", o_Miss, 1);
    release_btn();

    // Second note at counter 5: miss once, window restarts.
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    repeat (5) tick();                         // E5
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E6
    chk("renote_miss", o_Miss,       1);
    chk("renote_hit",  o_Hit,        0);
    chk("renote_open", o_WindowOpen, 1);
    tick();                                    // E7
    chk("renote_miss_1cyc", o_Miss,       0);
    chk("renote_open_hold", o_WindowOpen, 1);
    repeat (8) tick();                         // E15
    chk("renote_restart_early", o_Miss, 0);
    tick();                                    // E16
    chk("renote_restart_miss", o_Miss,       1);
    chk("renote_restart_open", o_WindowOpen, 0);

    // Open window + note + press: hit for old note, new window opens.
    i_Btn = 1'b1;
    repeat (3) tick();
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    tick(); tick();                            // E1, E2: press at counter 2
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E3
    chk("nh_hit",  o_Hit,        1);
    chk("nh_perf", o_Perfect,    1);
    chk("nh_miss", o_Miss,       0);
    chk("nh_open", o_WindowOpen, 1);
    repeat (9) tick();                         // E12
    chk("nh_miss_early", o_Miss, 0);
    tick();                                    // E13
    chk("nh_new_miss", o_Miss, 1);
    release_btn();

    // Idle + note + press same cycle: perfect hit, stays idle.
    i_Btn = 1'b1;
    repeat (6) tick();
    i_Note = 1'b1; tick(); i_Note = 1'b0;
    chk("in_hit",  o_Hit,        1);
    chk("in_perf", o_Perfect,    1);
    chk("in_open", o_WindowOpen, 0);
    release_btn();

    // Empty press in idle.
    i_Btn = 1'b1;
    repeat (6) tick();
    chk("empty_pre", o_Miss, 0);
    tick();
`ifdef EMPTY_PRESS_MISS_EN
    chk("empty_miss", o_Miss, 1);
`else
    chk("empty_miss", o_Miss, 0);
`endif
    chk("empty_hit", o_Hit, 0);
    release_btn();

    // Reset mid-window at counter 6: outputs clear, no later miss.
    i_Note = 1'b1; tick(); i_Note = 1'b0;
    repeat (6) tick();
    i_Rst = 1'b1;
    #1;
    chk("mrst_open",    o_WindowOpen, 0);
    chk("mrst_miss",    o_Miss,       0);
    chk("mrst_hit",     o_Hit,        0);
    chk("mrst_perfect", o_Perfect,    0);
    tick();
    i_Rst = 1'b0;
    hits = 0; misses = 0;
    count_outputs(15);
    chk("mrst_no_miss", misses, 0);
    chk("mrst_idle",    o_WindowOpen, 0);

    // Button held through reset release: press only after debouncing from 0.
    i_Btn = 1'b1;
    repeat (8) tick();
    i_Rst = 1'b1;
    tick();
    chk("hrst_hit", o_Hit, 0);
    i_Rst  = 1'b0;
    i_Note = 1'b1; tick(); i_Note = 1'b0;      // E0
    hits = 0; misses = 0;
    count_outputs(5);                          // E1..E5
    chk("hrst_no_early_hit", hits, 0);
    tick();                                    // E6
    chk("hrst_hit_late", o_Hit,     1);
    chk("hrst_perf",     o_Perfect, 0);
    release_btn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
